bcd_calc_core: RTL and testbench
================================

# bcd_calc_core

Parametrised, multi-cycle BCD calculator core: accepts two packed-BCD operands and an ASCII operator code, converts the operands to binary, executes add/subtract/multiply/divide, and returns a packed-BCD result with sign and error flags. It sits between the keypad/operand-entry logic and the seven-segment display driver. It is the successor to the single-cycle combinational calculator path: digit count is generic, the divider is sequential, and start/done handshaking is explicit.

## Interface
- DIGITS, default 3, number of BCD digits per operand (1..4)
- BW, default clog2(10^DIGITS), binary operand width (derived, not overridden)
- RDIGITS, default 2*DIGITS, BCD digits in result (derived)
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- num1  input  4*DIGITS  operand 1, packed BCD, MSD in top nibble
- num2  input  4*DIGITS  operand 2, same format
- sym  input  8  operator: 8'h61 add, 8'h62 sub, 8'h63 mul, 8'h64 div
- busy  output  1  high from start acceptance until done cycle inclusive
- done  output  1  one-cycle pulse, result valid
- result  output  4*RDIGITS  packed-BCD magnitude, MSD top
- neg  output  1  result negative (sub only)
- err  output  1  operation aborted
- err_code  output  2  0 none, 1 bad BCD digit, 2 bad operator, 3 divide by zero

## Operation
- FSM states: IDLE, CONV, EXEC, DAB, DONE.
- IDLE: start=1 captures num1, num2, sym into registers; go CONV. Inputs ignored otherwise.
- CONV: DIGITS cycles, MSD first, both operands in parallel: acc = acc*10 + digit. Any captured digit >9 sets err_code=1.
- After CONV, checks are done in priority order: bad digit, then sym outside 61..64 (code 2), then div with operand2==0 (code 3). Any error jumps to DONE with result=0, neg=0, err=1.
- EXEC add/sub/mul: 1 cycle. Width is 2*BW. Sub: if op2>op1, magnitude=op2-op1 and neg=1; otherwise neg=0. Zero result is never negative.
- EXEC div: restoring shift-subtract, BW cycles. Quotient is truncated, remainder discarded.
- DAB: double-dabble over the 2*BW-bit magnitude, 2*BW cycles. Add-3 is applied to every nibble >=5 before each shift.
- DONE: 1 cycle; done=1, err/neg/result updated this cycle. Then IDLE.
- Outputs hold their values until the next DONE. They are not cleared on a new start.
- start while busy: ignored, not queued.

## Timing
- Reset (rst_n=0 at edge): state IDLE; busy=0, done=0, result=0, neg=0, err=0, err_code=0. Takes effect mid-operation; the in-flight op is discarded with no done.
- Latency, start edge to done high: DIGITS + E + 2*BW + 1 cycles, where E=1 for add/sub/mul and E=BW for div. For DIGITS=3 (BW=10): add/sub/mul 25 cycles, div 34 cycles.
- Error path: done after DIGITS+1 cycles.
- busy rises the cycle after start is accepted and falls with the done cycle. start is accepted again the cycle after DONE.
- Maximum product (10^DIGITS-1)^2 fits in RDIGITS digits. No overflow flag is needed.

## Structure
- Package calc_pkg holds:
  - opcode constants OP_ADD..OP_DIV (8'h61..8'h64)
  - err_code enum
  - FSM state typedef
  - function for BW from DIGITS
- Sub-module bin2bcd_seq: iterative double-dabble with parameter IN_W.
  - Handshake load/done.
  - Reused by the display path.
- Divider stays inline in EXEC.

## Test plan
- 123 + 456, sym 8'h61 -> done at cycle 25, result 24'h000579, neg=0, err=0.
- 012 - 345, sym 8'h62 -> result 24'h000333, neg=1. Then 345-345 -> result 0, neg=0.
- 999 * 999, sym 8'h63 -> result 24'h998001.
- 100 / 007, sym 8'h64 -> done at cycle 34, result 24'h000014.
- Error cases, each with done at cycle 4, err=1, result 0:
  - divide by 000 -> err_code=3
  - num1=12'h1A3 -> err_code=1
  - sym=8'h65 -> err_code=2
- Busy/reset: pulse start again at cycle 5 -> ignored, one done only. Assert rst_n=0 at cycle 10 of a div -> all outputs 0, no done. A new start after reset completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the BCD calculator core.
//   OP_ADD..OP_DIV : ASCII operator codes accepted on 'sym'
//   err_code_e     : error code reported alongside 'err'
//   state_e        : calculator FSM states
//   calc_bw()      : binary width needed to hold any DIGITS-digit decimal value
package calc_pkg;

    localparam logic [7:0] OP_ADD = 8'h61;
    localparam logic [7:0] OP_SUB = 8'h62;
    localparam logic [7:0] OP_MUL = 8'h63;
    localparam logic [7:0] OP_DIV = 8'h64;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_BCD  = 2'd1,
        ERR_OP   = 2'd2,
        ERR_DIV0 = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_EXEC,
        S_DAB,
        S_DONE
    } state_e;

    // clog2(10^digits): smallest w with 2^w >= 10^digits
    function automatic int calc_bw(input int digits);
        longint p;
        int     w;
        p = 1;
        w = 0;
        for (int i = 0; i < digits; i++) p = p * 10;
        for (int i = 0; i < 40; i++) begin
            if ((longint'(1) << i) < p) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture 'bin' and start conversion (IN_W cycles)
//   bin        : binary input
//   done       : one-cycle pulse when 'bcd' holds the finished conversion
//   bcd        : packed BCD output, OUT_D digits, MSD in top nibble
// OUT_D may be set below the digit count IN_W could represent when the caller
// guarantees a smaller maximum value; every intermediate prefix is then also
// in range, so the truncated register stays exact.
module bin2bcd_seq #(
    parameter int IN_W  = 8,
    parameter int OUT_D = (IN_W + 2) / 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [IN_W-1:0]    bin,
    output logic               done,
    output logic [4*OUT_D-1:0] bcd
);
    localparam int SW = 4 * OUT_D + IN_W;
    localparam int CW = $clog2(IN_W + 1);

    // {bcd digits, remaining binary bits}; binary shifts into the digits
    logic [SW-1:0] sr_q;
    logic [SW-1:0] adj_d;
    logic [CW-1:0] cnt_q;
    logic          done_q;

    always_comb begin
        adj_d = sr_q;
        for (int i = 0; i < OUT_D; i++) begin
            if (sr_q[IN_W+4*i +: 4] >= 4'd5)
                adj_d[IN_W+4*i +: 4] = sr_q[IN_W+4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                sr_q  <= SW'(bin);
                cnt_q <= CW'(IN_W);
            end else if (cnt_q != '0) begin
                sr_q  <= adj_d << 1;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) done_q <= 1'b1;
            end
        end
    end

    assign done = done_q;
    assign bcd  = sr_q[SW-1 -: 4*OUT_D];

endmodule

// File: rtl/bcd_calc_core.sv
// Multi-cycle BCD calculator: BCD operands -> binary, add/sub/mul/div,
// result back to packed BCD via bin2bcd_seq.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : request, sampled only while idle
//   num1, num2   : packed-BCD operands, MSD in top nibble
//   sym          : ASCII operator (a/b/c/d = add/sub/mul/div)
//   busy         : high from acceptance through the done cycle
//   done         : one-cycle pulse, outputs below updated in that cycle
//   result       : packed-BCD magnitude, 2*DIGITS digits
//   neg          : result negative (subtract only)
//   err, err_code: aborted operation and its cause
// Outputs hold between done pulses.
module bcd_calc_core
    import calc_pkg::*;
#(
    parameter  int DIGITS  = 3,
    localparam int BW      = calc_bw(DIGITS),
    localparam int RDIGITS = 2 * DIGITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*DIGITS-1:0]  num1,
    input  logic [4*DIGITS-1:0]  num2,
    input  logic [7:0]           sym,
    output logic                 busy,
    output logic                 done,
    output logic [4*RDIGITS-1:0] result,
    output logic                 neg,
    output logic                 err,
    output logic [1:0]           err_code
);
    localparam int CW = $clog2(BW + 1);
    localparam int MW = 2 * BW;

    state_e               state_q;
    logic [4*DIGITS-1:0]  n1_q, n2_q;
    logic [7:0]           sym_q;
    logic [BW-1:0]        acc1_q, acc2_q;
    logic [BW-1:0]        dvd_q, rem_q;
    logic [CW-1:0]        cnt_q;
    logic                 bad_q, negp_q;
    logic                 busy_q, done_q, neg_q, err_q;
    logic [4*RDIGITS-1:0] result_q;
    err_code_e            errc_q;

    // Decimal-to-binary step: operand registers shift MSD-first
    logic [3:0]    dig1, dig2;
    logic [BW-1:0] acc1_d, acc2_d;
    logic          bad_d;

    assign dig1   = n1_q[4*DIGITS-1 -: 4];
    assign dig2   = n2_q[4*DIGITS-1 -: 4];
    assign acc1_d = acc1_q * BW'(10) + BW'(dig1);
    assign acc2_d = acc2_q * BW'(10) + BW'(dig2);
    assign bad_d  = bad_q | (dig1 > 4'd9) | (dig2 > 4'd9);

    // Error priority: bad digit, bad operator, divide by zero
    logic      op_ok, is_div;
    err_code_e errc_d;

    assign op_ok  = (sym_q >= OP_ADD) && (sym_q <= OP_DIV);
    assign is_div = (sym_q == OP_DIV);

    always_comb begin
        errc_d = ERR_NONE;
        if (bad_q)                           errc_d = ERR_BCD;
        else if (!op_ok)                     errc_d = ERR_OP;
        else if (is_div && (acc2_q == '0))   errc_d = ERR_DIV0;
    end

    // Restoring divider step: dvd_q shifts dividend bits out the top and
    // quotient bits in at the bottom, so it ends holding the quotient.
    logic [BW:0]   rem_sh;
    logic          qbit;
    logic [BW-1:0] rem_d, quo_d;

    assign rem_sh = {rem_q, dvd_q[BW-1]};
    assign qbit   = (rem_sh >= {1'b0, acc2_q});
    assign rem_d  = qbit ? BW'(rem_sh - {1'b0, acc2_q}) : rem_sh[BW-1:0];
    assign quo_d  = {dvd_q[BW-2:0], qbit};

    // Result magnitude handed to the BCD converter
    logic [MW-1:0] a_ext, b_ext, mag_d;
    logic          negp_d;

    assign a_ext = MW'(acc1_q);
    assign b_ext = MW'(acc2_q);

    always_comb begin
        mag_d  = '0;
        negp_d = 1'b0;
        case (sym_q)
            OP_ADD: mag_d = a_ext + b_ext;
            OP_SUB: begin
                if (b_ext > a_ext) begin
                    mag_d  = b_ext - a_ext;
                    negp_d = 1'b1;
                end else begin
                    mag_d  = a_ext - b_ext;
                end
            end
            OP_MUL:  mag_d = a_ext * b_ext;
            default: mag_d = MW'(quo_d);
        endcase
    end

    // Load on the single EXEC cycle of add/sub/mul, or the last divide step
    logic                 b2b_load, b2b_done;
    logic [4*RDIGITS-1:0] b2b_bcd;

    assign b2b_load = (state_q == S_EXEC) && (errc_d == ERR_NONE) &&
                      (!is_div || (cnt_q == CW'(BW - 1)));

    bin2bcd_seq #(
        .IN_W  (MW),
        .OUT_D (RDIGITS)
    ) u_b2b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (b2b_load),
        .bin   (mag_d),
        .done  (b2b_done),
        .bcd   (b2b_bcd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            n1_q     <= '0;
            n2_q     <= '0;
            sym_q    <= '0;
            acc1_q   <= '0;
            acc2_q   <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            bad_q    <= 1'b0;
            negp_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            errc_q   <= ERR_NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n1_q    <= num1;
                        n2_q    <= num2;
                        sym_q   <= sym;
                        acc1_q  <= '0;
                        acc2_q  <= '0;
                        bad_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    acc1_q <= acc1_d;
                    acc2_q <= acc2_d;
                    bad_q  <= bad_d;
                    n1_q   <= n1_q << 4;
                    n2_q   <= n2_q << 4;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DIGITS - 1)) begin
                        cnt_q   <= '0;
                        dvd_q   <= acc1_d;
                        rem_q   <= '0;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (errc_d != ERR_NONE) begin
                        result_q <= '0;
                        neg_q    <= 1'b0;
                        err_q    <= 1'b1;
                        errc_q   <= errc_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        negp_q <= negp_d;
                        if (is_div) begin
                            dvd_q <= quo_d;
                            rem_q <= rem_d;
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (b2b_load) state_q <= S_DAB;
                    end
                end
                S_DAB: begin
                    if (b2b_done) begin
                        result_q <= b2b_bcd;
                        neg_q    <= negp_q;
                        err_q    <= 1'b0;
                        errc_q   <= ERR_NONE;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign neg      = neg_q;
    assign err      = err_q;
    assign err_code = errc_q;

endmodule

// File: tb/tb_bcd_calc_core.sv
// Bench for bcd_calc_core (DIGITS=3): directed cases with literal
// expectations plus randomized traffic checked every cycle against a
// decimal-arithmetic model.
module tb_bcd_calc_core;

    localparam int DIGITS = 3;
    localparam int BW     = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] num1 = '0;
    logic [11:0] num2 = '0;
    logic [7:0]  sym = '0;
    logic        busy, done, neg, err;
    logic [23:0] result;
    logic [1:0]  err_code;

    bcd_calc_core #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num1     (num1),
        .num2     (num2),
        .sym      (sym),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .neg      (neg),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int done_count = 0;
    bit chk_en = 1'b0;

    // Model timeline (in cyc units) and expected/held outputs
    int          done_at = -100, busy_from = 1, busy_to = 0, idle_from = 0, skip_cyc = -1;
    logic [23:0] e_res = '0, h_res = '0;
    logic        e_neg = 1'b0, h_neg = 1'b0, e_err = 1'b0, h_err = 1'b0;
    logic [1:0]  e_ec = '0, h_ec = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Decimal behaviour from the operator rules
    task automatic model(input logic [11:0] a, input logic [11:0] b, input logic [7:0] s,
                         output logic [23:0] r, output logic ng, output logic er,
                         output logic [1:0] ec, output int lat);
        int  va, vb, m;
        bit  bad;
        va = 0; vb = 0; bad = 0; m = 0; ng = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) bad = 1;
            va += int'(a[4*i +: 4]) * (10 ** i);
            vb += int'(b[4*i +: 4]) * (10 ** i);
        end
        if (bad)                      ec = 2'd1;
        else if (s < 8'h61 || s > 8'h64) ec = 2'd2;
        else if (s == 8'h64 && vb == 0)  ec = 2'd3;
        else                          ec = 2'd0;
        er = (ec != 0);
        if (!er) begin
            case (s)
                8'h61:   m = va + vb;
                8'h62:   begin m = (va >= vb) ? va - vb : vb - va; ng = (vb > va); end
                8'h63:   m = va * vb;
                default: m = va / vb;
            endcase
        end
        for (int i = 0; i < 2 * DIGITS; i++) r[4*i +: 4] = 4'((m / (10 ** i)) % 10);
        if (er)              lat = DIGITS + 1;
        else if (s == 8'h64) lat = DIGITS + BW + 2 * BW + 1;
        else                 lat = DIGITS + 1 + 2 * BW + 1;
    endtask

    // Per-cycle check of every output against the model timeline
    bit xd, xb;
    always @(negedge clk) begin
        if (chk_en) begin
            xd = (cyc == done_at);
            xb = (cyc >= busy_from) && (cyc <= busy_to);
            chk("done", 64'(done), 64'(xd));
            chk("busy", 64'(busy), 64'(xb));
            if (xd) begin
                h_res = e_res; h_neg = e_neg; h_err = e_err; h_ec = e_ec;
            end
            if (cyc != skip_cyc) begin
                chk("result", 64'(result), 64'(h_res));
                chk("neg", 64'(neg), 64'(h_neg));
                chk("err", 64'(err), 64'(h_err));
                chk("err_code", 64'(err_code), 64'(h_ec));
            end
        end
        if (done === 1'b1) done_count++;
    end

    // Drive one cycle of inputs; the model takes the request only when idle
    task automatic drive(input logic [11:0] a, input logic [11:0] b,
                         input logic [7:0] s, input bit st);
        int lat;
        num1 = a; num2 = b; sym = s; start = st;
        if (st && rst_n && cyc >= idle_from) begin
            model(a, b, s, e_res, e_neg, e_err, e_ec, lat);
            busy_from = cyc + 1;
            done_at   = cyc + 1 + lat;
            busy_to   = done_at;
            idle_from = done_at + 1;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (cyc < idle_from && t < 200) begin drive(12'h0, 12'h0, 8'h0, 1'b0); t++; end
    endtask

    task automatic run_op(input logic [11:0] a, input logic [11:0] b, input logic [7:0] s,
                          input int x_lat, input logic [23:0] x_res, input logic x_neg,
                          input logic x_err, input logic [1:0] x_ec, input string nm);
        int k0, t;
        wait_idle();
        drive(a, b, s, 1'b1);
        k0 = cyc;
        t = 0;
        while (done !== 1'b1 && t < 80) begin drive(a, b, s, 1'b0); t++; end
        chk({nm, " latency"}, 64'(cyc - k0), 64'(x_lat));
        chk({nm, " result"}, 64'(result), 64'(x_res));
        chk({nm, " neg"}, 64'(neg), 64'(x_neg));
        chk({nm, " err"}, 64'(err), 64'(x_err));
        chk({nm, " err_code"}, 64'(err_code), 64'(x_ec));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if (busy_to > cyc) busy_to = cyc;
        done_at  = -100;
        skip_cyc = cyc;
        h_res = '0; h_neg = 1'b0; h_err = 1'b0; h_ec = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        idle_from = cyc;
    endtask

    function automatic logic [11:0] rand_bcd();
        logic [11:0] v;
        if ($urandom_range(0, 7) == 0) return 12'h000;
        for (int i = 0; i < DIGITS; i++)
            v[4*i +: 4] = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
        return v;
    endfunction

    function automatic logic [7:0] rand_sym();
        if ($urandom_range(0, 15) == 0) return 8'($urandom_range(0, 255));
        return 8'h61 + 8'($urandom_range(0, 3));
    endfunction

    initial begin
        int d0, k0, t;
        logic [11:0] ra, rb;
        logic [7:0]  rs;

        repeat (3) begin @(posedge clk); #1; end
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst result", 64'(result), 64'(0));
        chk("rst flags", 64'({neg, err, err_code}), 64'(0));
        rst_n = 1'b1;
        idle_from = cyc;
        chk_en = 1'b1;

        run_op(12'h123, 12'h456, 8'h61, 25, 24'h000579, 1'b0, 1'b0, 2'd0, "add");
        run_op(12'h012, 12'h345, 8'h62, 25, 24'h000333, 1'b1, 1'b0, 2'd0, "sub neg");
        run_op(12'h345, 12'h345, 8'h62, 25, 24'h000000, 1'b0, 1'b0, 2'd0, "sub zero");
        run_op(12'h999, 12'h999, 8'h63, 25, 24'h998001, 1'b0, 1'b0, 2'd0, "mul max");
        run_op(12'h100, 12'h007, 8'h64, 34, 24'h000014, 1'b0, 1'b0, 2'd0, "div");
        run_op(12'h999, 12'h000, 8'h64, 4, 24'h000000, 1'b0, 1'b1, 2'd3, "div0");
        run_op(12'h1A3, 12'h123, 8'h61, 4, 24'h000000, 1'b0, 1'b1, 2'd1, "bad digit");
        run_op(12'h123, 12'h456, 8'h65, 4, 24'h000000, 1'b0, 1'b1, 2'd2, "bad op");
        run_op(12'h1A3, 12'h000, 8'h70, 4, 24'h000000, 1'b0, 1'b1, 2'd1, "err priority");

        // Second start while busy must be ignored
        wait_idle();
        d0 = done_count;
        drive(12'h123, 12'h456, 8'h61, 1'b1);
        repeat (4) drive(12'h999, 12'h999, 8'h63, 1'b0);
        drive(12'h999, 12'h999, 8'h63, 1'b1);
        t = 0;
        while (done !== 1'b1 && t < 80) begin drive(12'h0, 12'h0, 8'h0, 1'b0); t++; end
        chk("busy-start result", 64'(result), 64'(24'h000579));
        repeat (40) drive(12'h0, 12'h0, 8'h0, 1'b0);
        chk("busy-start done count", 64'(done_count - d0), 64'(1));

        // Reset in the middle of a divide
        wait_idle();
        drive(12'h100, 12'h007, 8'h64, 1'b1);
        k0 = cyc;
        while (cyc < k0 + 10) drive(12'h0, 12'h0, 8'h0, 1'b0);
        do_reset();
        chk("mid-rst busy", 64'(busy), 64'(0));
        chk("mid-rst done", 64'(done), 64'(0));
        chk("mid-rst result", 64'(result), 64'(0));
        chk("mid-rst flags", 64'({neg, err, err_code}), 64'(0));
        d0 = done_count;
        repeat (40) drive(12'h0, 12'h0, 8'h0, 1'b0);
        chk("mid-rst no done", 64'(done_count - d0), 64'(0));
        run_op(12'h250, 12'h250, 8'h61, 25, 24'h000500, 1'b0, 1'b0, 2'd0, "post-rst add");

        // Random traffic, including starts that land while busy
        for (int n = 0; n < 3000; n++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            rs = rand_sym();
            drive(ra, rb, rs, ($urandom_range(0, 3) == 0));
        end
        wait_idle();
        repeat (3) drive(12'h0, 12'h0, 8'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
